// File: rtl/alu_add_seq.sv
// Multi-cycle adder: one SLICE-bit adder slice reused LSB first, carry held in a register between slices.
// Optional macro ALU_ADD_SEQ_SUB_EN adds a 'sub' input (X - Y computed as X + ~Y + 1).
module alu_add_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
`ifdef ALU_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             Sign,
  output logic             Zero,
  output logic             Carry,
  output logic             Parity,
  output logic             Overflow
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | one slice per edge, slice index = cnt
  // S_DONE | result and flags valid, done pulse; start here chains the next op

  localparam int NSTEP = WIDTH / SLICE;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              carry_r;
  logic [WIDTH-1:0]  xr, yr;
  logic [WIDTH-1:0]  y_eff;
  logic [WIDTH-1:0]  z_new;
  logic [SLICE-1:0]  xs, ys;
  logic [SLICE:0]    sum;
  logic              cin0;
  logic              capture, step, last;

`ifdef ALU_ADD_SEQ_SUB_EN
  logic sub_r;

  always_comb begin
    cin0  = sub;
    y_eff = sub_r ? ~yr : yr;
  end
`else
  always_comb begin
    cin0  = 1'b0;
    y_eff = yr;
  end
`endif

  // Slice adder; z_new is Z with the current slice replaced, used for the final flags.
  always_comb begin
    xs    = xr[int'(cnt)*SLICE +: SLICE];
    ys    = y_eff[int'(cnt)*SLICE +: SLICE];
    sum   = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, carry_r};
    z_new = Z;
    z_new[int'(cnt)*SLICE +: SLICE] = sum[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: capture = start;
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        last = (cnt == CW'(NSTEP - 1));
      end
      S_DONE: begin
        done    = 1'b1;
        capture = start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      carry_r  <= 1'b0;
      xr       <= '0;
      yr       <= '0;
`ifdef ALU_ADD_SEQ_SUB_EN
      sub_r    <= 1'b0;
`endif
      Z        <= '0;
      Sign     <= 1'b0;
      Zero     <= 1'b0;
      Carry    <= 1'b0;
      Parity   <= 1'b0;
      Overflow <= 1'b0;
    end else if (capture) begin
      xr      <= X;
      yr      <= Y;
      cnt     <= '0;
      carry_r <= cin0;
`ifdef ALU_ADD_SEQ_SUB_EN
      sub_r   <= sub;
`endif
    end else if (step) begin
      Z       <= z_new;
      carry_r <= sum[SLICE];
      cnt     <= cnt + CW'(1);
      // Flags only change on the final slice so they hold through RUN.
      if (last) begin
        Carry    <= sum[SLICE];
        Sign     <= z_new[WIDTH-1];
        Zero     <= (z_new == '0);
        Parity   <= ~^z_new;
        Overflow <= (xr[WIDTH-1] & y_eff[WIDTH-1] & ~z_new[WIDTH-1]) |
                    (~xr[WIDTH-1] & ~y_eff[WIDTH-1] & z_new[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_alu_add_seq.sv
// Directed self-checking bench for alu_add_seq; flags are compared as {Sign,Zero,Carry,Parity,Overflow}.
module tb_alu_add_seq;
  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] X, Y, Z;
  logic        busy, done, Sign, Zero, Carry, Parity, Overflow;
  logic [4:0]  flags;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          lat, busy_n, d0;

  assign flags = {Sign, Zero, Carry, Parity, Overflow};

  alu_add_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y),
`ifdef ALU_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .Z(Z), .Sign(Sign), .Zero(Zero),
    .Carry(Carry), .Parity(Parity), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is high for the edge that follows, then operands are scrambled.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    X = a; Y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; X = 16'hDEAD; Y = 16'hBEEF;
  endtask

  // Starts one negedge after the capture edge; lat counts negedges since the start-asserting one.
  task automatic wait_done(output int l, output int b);
    l = 1; b = 0;
    while (!done && l < 40) begin
      if (busy) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ez, input logic [4:0] ef);
    start_op(a, b);
    wait_done(lat, busy_n);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_busy"}, busy_n, 4);
    check({tag, "_z"}, Z, ez);
    check({tag, "_flags"}, flags, ef);
    @(negedge clk);
    check({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {busy, done}, 2'b00);
    check("rst_z", Z, 16'h0000);
    check("rst_flags", flags, 5'b00000);
    rst = 1'b0;
    @(negedge clk);

    run_op("one_one", 16'h0001, 16'h0001, 16'h0002, 5'b00000);
    run_op("ripple",  16'hFFFF, 16'h0001, 16'h0000, 5'b01110);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 16'h8000, 5'b10001);
    run_op("ovf_neg", 16'h8000, 16'h8000, 16'h0000, 5'b01111);

    // start re-pulsed mid-RUN must be ignored; start held in DONE chains the next op.
    d0 = done_cnt;
    start_op(16'h1234, 16'h1111);
    @(negedge clk);
    X = 16'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    check("ignore_lat", lat, 2);
    check("ignore_z", Z, 16'h2345);
    check("ignore_flags", flags, 5'b00010);
    start_op(16'h0F0F, 16'h00F1);
    check("b2b_nobubble", {busy, done}, 2'b10);
    wait_done(lat, busy_n);
    check("b2b_lat", lat, 5);
    check("b2b_z", Z, 16'h1000);
    check("b2b_flags", flags, 5'b00000);
    @(negedge clk);
    check("b2b_pulses", done_cnt - d0, 2);

    // Abort mid-RUN with reset; previous result 0x8000/flags 10001 must be cleared.
    run_op("pre_abort", 16'h7FFF, 16'h0001, 16'h8000, 5'b10001);
    d0 = done_cnt;
    start_op(16'h00FF, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctrl", {busy, done}, 2'b00);
    check("abort_z", Z, 16'h0000);
    check("abort_flags", flags, 5'b00000);
    repeat (6) @(negedge clk);
    check("abort_nodone", done_cnt - d0, 0);
    run_op("after_abort", 16'h0003, 16'h0004, 16'h0007, 5'b00000);

    // Reset wins over a simultaneous start.
    rst = 1'b1; X = 16'h0001; Y = 16'h0001; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_wins", {busy, done}, 2'b00);
    @(negedge clk);

`ifdef ALU_ADD_SEQ_SUB_EN
    sub = 1'b1;
    run_op("sub_neg", 16'h0005, 16'h0007, 16'hFFFE, 5'b10000);
    run_op("sub_ovf", 16'h8000, 16'h0001, 16'h7FFF, 5'b00101);
    sub = 1'b0;
    run_op("sub_off", 16'h0005, 16'h0007, 16'h000C, 5'b00010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_add_seq.md
Name: alu_add_seq

Overview:
- Multi-cycle sequencer for 16-bit addition that reuses a single SLICE-bit adder slice, one slice per clock, LSB first.
- Latches operands on a start handshake and ripples the carry through a register between slices.
- Produces the same result and flag set as the combinational ALU adder (Z, Sign, Zero, Carry, Parity, Overflow), trading latency for area.
- Sits between the instruction control FSM and the register file write-back.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, adder slice width in bits; NSTEP = WIDTH/SLICE slices per operation.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- X  input  WIDTH  operand A; captured on the accepted start edge.
- Y  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when Z and flags become valid.
- Z  output  WIDTH  sum; held until the next accepted start.
- Sign  output  1  Z[WIDTH-1].
- Zero  output  1  1 when Z==0.
- Carry  output  1  carry out of the MSB slice.
- Parity  output  1  even-parity flag, ~^Z (1 when Z has an even number of ones).
- Overflow  output  1  signed overflow: (Xm & Ym & ~Zm) | (~Xm & ~Ym & Zm), using operand and result MSBs.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, slice counter=0, carry register=0, operand registers=0; busy, done, Z and all flags = 0.
- States:
  - IDLE: start=1 -> latch X, Y; counter=0; carry=0 (cin of slice 0 is 0) -> RUN.
  - RUN: each edge computes {c, Z[k*SLICE +: SLICE]} = Xr slice + Yr slice + carry for k = counter. Writes that Z slice, stores c, increments counter. When k = NSTEP-1: register Carry=c, compute Sign/Zero/Parity/Overflow from the complete new Z, done=1 -> DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> same capture as IDLE, straight to RUN. Otherwise -> IDLE.
- Latency: start accepted at edge E0; slices processed at edges E1..ENSTEP; done=1 in the cycle after edge ENSTEP (NSTEP+1 edges after the capture edge is counted from E0). busy=1 from after E0 until after ENSTEP.
- Back-to-back: start held high in the DONE cycle gives a new operation with no idle bubble.
- Intermediate values: Z slices update as they are computed; Z is only architecturally valid while done=1 and afterwards. Flags are updated only at the final slice and keep their previous values during RUN.
- start while busy=1 is ignored: operands are not re-captured and the in-flight result is unaffected.
- X/Y changes after the capture edge have no effect.
- Arithmetic is modulo 2^WIDTH; the carry between slices is a 1-bit register.
- rst during RUN or DONE aborts the operation: next state IDLE, outputs zeroed as at reset, no done pulse. rst wins over a simultaneous start.

Optional Feature:
- Macro ALU_ADD_SEQ_SUB_EN.
- Defined: extra input port sub (1 bit), captured with the operands. When sub=1 the operation is X - Y, computed as X + ~Y with slice-0 cin=1. Overflow uses the MSB of the effective operand ~Y. Carry = raw carry out (1 means no borrow).
- Not defined: no sub port; addition only, slice-0 cin is always 0.

Test Plan:
- X=0x0001, Y=0x0001, start one cycle -> done exactly NSTEP=4 cycles after the capture cycle; Z=0x0002, Sign=0, Zero=0, Carry=0, Parity=0, Overflow=0; busy high 4 cycles.
- X=0xFFFF, Y=0x0001 -> Z=0x0000, Carry=1, Zero=1, Parity=1, Sign=0, Overflow=0 (carry ripples through all 4 slices).
- X=0x7FFF, Y=0x0001 -> Z=0x8000, Sign=1, Overflow=1, Carry=0, Zero=0, Parity=0. Then X=0x8000, Y=0x8000 -> Z=0x0000, Carry=1, Overflow=1, Zero=1, Parity=1.
- First operation X=0x1234, Y=0x1111 accepted. start re-pulsed mid-RUN with X=0xAAAA -> ignored; Z=0x2345 and only one done pulse. start held high in the DONE cycle with X=0x0F0F, Y=0x00F1 -> no idle gap; Z=0x1000.
- rst=1 on the second RUN cycle of X=0x00FF, Y=0x0001 -> next cycle busy=0, done=0, Z=0, all flags 0, state IDLE, no done pulse. A following start with X=0x0003, Y=0x0004 -> Z=0x0007.
- ALU_ADD_SEQ_SUB_EN defined, sub=1, X=0x0005, Y=0x0007 -> Z=0xFFFE, Sign=1, Carry=0, Overflow=0, Parity=0, Zero=0. sub=1, X=0x8000, Y=0x0001 -> Z=0x7FFF, Overflow=1, Carry=1.
